// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the iterative shift unit.
//   OP_*     3-bit operation codes carried on in_op (110/111 behave as pass)
//   state_e  control states of shift_unit: IDLE, SHIFT, DONE
// ---------------------------------------------------------------------------
package shift_pkg;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_LSL  = 3'b001;
  localparam logic [2:0] OP_LSR  = 3'b010;
  localparam logic [2:0] OP_ASR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// ---------------------------------------------------------------------------
// shift_step
// Combinational single-step shifter used once per SHIFT cycle.
//   data    in   WIDTH  word being shifted
//   op      in   3      operation code (see shift_pkg)
//   amount  in   AW     bit positions to move this step (0..STEP)
//   result  out  WIDTH  shifted / rotated word
//   carry   out  1      last bit pushed out (shifts) or wrapped (rotates);
//                       0 when amount is 0 or op is pass
// ---------------------------------------------------------------------------
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    amount,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam logic [AW-1:0] W_AMT = AW'(WIDTH);

  // The carry of a left shift is the bit at position WIDTH-amount, of a right
  // shift the bit at amount-1; both are picked with a compare loop so no
  // partially used intermediate vectors are needed.
  always_comb begin
    result = data;
    carry  = 1'b0;
    if (amount != '0) begin
      case (op)
        OP_LSL: begin
          result = data << amount;
          for (int i = 0; i < WIDTH; i++) begin
            if (i == WIDTH - int'(amount)) carry = data[i];
          end
        end
        OP_LSR: begin
          result = data >> amount;
          for (int i = 0; i < WIDTH; i++) begin
            if (i == int'(amount) - 1) carry = data[i];
          end
        end
        OP_ASR: begin
          result = WIDTH'($signed(data) >>> amount);
          for (int i = 0; i < WIDTH; i++) begin
            if (i == int'(amount) - 1) carry = data[i];
          end
        end
        OP_ROL: begin
          result = (data << amount) | (data >> (W_AMT - amount));
          carry  = result[0];
        end
        OP_ROR: begin
          result = (data >> amount) | (data << (W_AMT - amount));
          carry  = result[WIDTH-1];
        end
        default: begin
          result = data;
          carry  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_unit.sv
// ---------------------------------------------------------------------------
// shift_unit
// Iterative barrel-free shifter: moves at most STEP bit positions per cycle
// through a single shift_step instance, with a valid/ready request side and
// a valid/ready result side. One operation in flight at a time.
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous active-high reset
//   flush      in   1      synchronous abort of the current operation
//   in_valid   in   1      request valid
//   in_ready   out  1      unit can accept a request (IDLE only)
//   in_data    in   WIDTH  operand
//   in_op      in   3      operation code (see shift_pkg)
//   in_amt     in   AW     shift amount
//   out_valid  out  1      result valid (DONE only)
//   out_ready  in   1      consumer accepts the result
//   out_data   out  WIDTH  result
//   out_carry  out  1      last bit shifted or rotated out
//   out_zero   out  1      out_data == 0
//   out_neg    out  1      out_data[WIDTH-1]
// ---------------------------------------------------------------------------
module shift_unit
  import shift_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int STEP  = 1,
  localparam int AW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  input  logic [AW-1:0]    in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_neg
);

  localparam logic [AW-1:0] W_AMT    = AW'(WIDTH);
  localparam logic [AW-1:0] STEP_AMT = AW'(STEP);

  state_e           state;
  logic [WIDTH-1:0] data_q;
  logic [2:0]       op_q;
  logic [AW-1:0]    rem_q;

  logic [AW-1:0]    eff_amt;
  logic [AW-1:0]    step_amt;
  logic [WIDTH-1:0] step_data;
  logic             step_carry;

  // Shifts saturate at WIDTH (everything is pushed out), rotates wrap modulo
  // WIDTH so the iteration never spins a full turn; pass never iterates.
  always_comb begin
    eff_amt = '0;
    case (in_op)
      OP_LSL, OP_LSR, OP_ASR: eff_amt = (in_amt > W_AMT) ? W_AMT : in_amt;
      OP_ROL, OP_ROR:         eff_amt = in_amt % W_AMT;
      default:                eff_amt = '0;
    endcase
  end

  assign step_amt = (rem_q > STEP_AMT) ? STEP_AMT : rem_q;

  shift_step #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_step (
    .data   (data_q),
    .op     (op_q),
    .amount (step_amt),
    .result (step_data),
    .carry  (step_carry)
  );

  // Outputs are loaded on the edge that enters DONE and cleared on every exit
  // from DONE, so they read as zero whenever out_valid is low. Reset is
  // checked before flush so it wins when both are high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      data_q    <= '0;
      op_q      <= OP_PASS;
      rem_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
      out_neg   <= 1'b0;
    end else if (flush) begin
      state     <= ST_IDLE;
      rem_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
      out_neg   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            data_q   <= in_data;
            op_q     <= in_op;
            rem_q    <= eff_amt;
            in_ready <= 1'b0;
            if (eff_amt == '0) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              out_data  <= in_data;
              out_carry <= 1'b0;
              out_zero  <= (in_data == '0);
              out_neg   <= in_data[WIDTH-1];
            end else begin
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          data_q <= step_data;
          rem_q  <= rem_q - step_amt;
          if (rem_q == step_amt) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            out_data  <= step_data;
            out_carry <= step_carry;
            out_zero  <= (step_data == '0);
            out_neg   <= step_data[WIDTH-1];
          end
        end
        ST_DONE: begin
          // in_ready only rises after this edge, so no request can be taken
          // on the same edge that the result is consumed.
          if (out_ready) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_carry <= 1'b0;
            out_zero  <= 1'b0;
            out_neg   <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
// ---------------------------------------------------------------------------
// tb_shift_unit
// Drives two shift_unit instances (STEP=1 and STEP=4, WIDTH=16) and compares
// results, flags and latency against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_shift_unit;

  localparam int WIDTH = 16;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  logic             in_valid  [2];
  logic             in_ready  [2];
  logic [WIDTH-1:0] in_data   [2];
  logic [2:0]       in_op     [2];
  logic [AW-1:0]    in_amt    [2];
  logic             out_valid [2];
  logic             out_ready [2];
  logic [WIDTH-1:0] out_data  [2];
  logic             out_carry [2];
  logic             out_zero  [2];
  logic             out_neg   [2];

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] rd;
  logic             rc, rz, rn;

  always #5 clk = ~clk;

  shift_unit #(.WIDTH(WIDTH), .STEP(1)) dut_s1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .in_op(in_op[0]), .in_amt(in_amt[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_carry(out_carry[0]), .out_zero(out_zero[0]), .out_neg(out_neg[0])
  );

  shift_unit #(.WIDTH(WIDTH), .STEP(4)) dut_s4 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .in_op(in_op[1]), .in_amt(in_amt[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_carry(out_carry[1]), .out_zero(out_zero[1]), .out_neg(out_neg[1])
  );

  function automatic int step_of(input int u);
    return (u == 0) ? 1 : 4;
  endfunction

  // Whole-operation model: the final word is computed in one go from the
  // effective amount, independent of how many cycles the unit takes.
  function automatic void ref_model(input logic [15:0] d, input logic [2:0] op,
                                    input int amt, output logic [15:0] r,
                                    output logic c, output int k);
    int dv;
    int s;
    dv = int'(d);
    s  = int'($signed(d));
    r  = d;
    c  = 1'b0;
    k  = 0;
    case (op)
      3'b001: begin
        k = (amt > 16) ? 16 : amt;
        r = 16'((dv << k) & 'hFFFF);
        if (k > 0) c = 1'((dv >> (16 - k)) & 1);
      end
      3'b010: begin
        k = (amt > 16) ? 16 : amt;
        r = 16'(dv >> k);
        if (k > 0) c = 1'((dv >> (k - 1)) & 1);
      end
      3'b011: begin
        k = (amt > 16) ? 16 : amt;
        r = 16'(s >>> k);
        if (k > 0) c = 1'((s >>> (k - 1)) & 1);
      end
      3'b100: begin
        k = amt % 16;
        r = 16'(((dv << k) | (dv >> (16 - k))) & 'hFFFF);
        if (k > 0) c = r[0];
      end
      3'b101: begin
        k = amt % 16;
        r = 16'(((dv >> k) | (dv << (16 - k))) & 'hFFFF);
        if (k > 0) c = r[15];
      end
      default: begin
        k = 0;
        r = d;
        c = 1'b0;
      end
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Issue one request on unit u, wait for the result, hold it for 'hold'
  // cycles of backpressure, then consume it while a new request is offered.
  task automatic apply_stimulus(input int u, input logic [15:0] d,
                                input logic [2:0] op, input int amt,
                                input int hold, output logic [15:0] o_data,
                                output logic o_carry, output logic o_zero,
                                output logic o_neg);
    logic [15:0] er;
    logic        ec;
    int          k;
    int          waited;
    int          lat;
    ref_model(d, op, amt, er, ec, k);
    waited = 0;
    while (!in_ready[u] && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check_output("in_ready_before_req", 32'(in_ready[u]), 32'd1);
    in_valid[u] = 1'b1;
    in_data[u]  = d;
    in_op[u]    = op;
    in_amt[u]   = AW'(amt);
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
    lat = 0;
    while (!out_valid[u] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (k == 0) check_output("latency_k0", 32'(lat <= 1), 32'd1);
    else        check_output("latency", 32'(lat), 32'((k + step_of(u) - 1) / step_of(u)));
    check_output("out_valid", 32'(out_valid[u]), 32'd1);
    check_output("out_data", 32'(out_data[u]), 32'(er));
    check_output("out_carry", 32'(out_carry[u]), 32'(ec));
    check_output("out_zero", 32'(out_zero[u]), 32'(er == 16'h0));
    check_output("out_neg", 32'(out_neg[u]), 32'(er[15]));
    o_data  = out_data[u];
    o_carry = out_carry[u];
    o_zero  = out_zero[u];
    o_neg   = out_neg[u];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_output("hold_valid", 32'(out_valid[u]), 32'd1);
      check_output("hold_data", 32'(out_data[u]), 32'(er));
      check_output("hold_flags", {29'd0, out_carry[u], out_zero[u], out_neg[u]},
                   {29'd0, ec, er == 16'h0, er[15]});
      check_output("hold_in_ready", 32'(in_ready[u]), 32'd0);
    end
    out_ready[u] = 1'b1;
    in_valid[u]  = 1'b1;
    in_data[u]   = 16'hFFFF;
    in_op[u]     = 3'b000;
    @(posedge clk); #1;
    out_ready[u] = 1'b0;
    in_valid[u]  = 1'b0;
    check_output("consumed_valid", 32'(out_valid[u]), 32'd0);
    check_output("consumed_data", 32'(out_data[u]), 32'd0);
    check_output("consumed_flags", {29'd0, out_carry[u], out_zero[u], out_neg[u]}, 32'd0);
    check_output("in_ready_after_consume", 32'(in_ready[u]), 32'd1);
  endtask

  // Starts LSL 16'h00FF by 8 on the STEP=1 unit and aborts it in its second
  // SHIFT cycle with flush or reset while a new request is also offered.
  task automatic abort_test(input bit use_reset, input string tag);
    in_valid[0] = 1'b1;
    in_data[0]  = 16'h00FF;
    in_op[0]    = 3'b001;
    in_amt[0]   = AW'(8);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    if (use_reset) reset = 1'b1;
    else           flush = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0]  = 16'h5555;
    in_op[0]    = 3'b000;
    @(posedge clk); #1;
    reset       = 1'b0;
    flush       = 1'b0;
    in_valid[0] = 1'b0;
    check_output({tag, "_out_valid"}, 32'(out_valid[0]), 32'd0);
    check_output({tag, "_out_data"}, 32'(out_data[0]), 32'd0);
    check_output({tag, "_in_ready"}, 32'(in_ready[0]), 32'd1);
    apply_stimulus(0, 16'h0001, 3'b001, 1, 0, rd, rc, rz, rn);
    check_output({tag, "_follow_data"}, 32'(rd), 32'h0002);
  endtask

  initial begin
    int u;
    logic [15:0] d;
    logic [2:0]  op;
    int          amt;
    int          hold;

    reset = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      in_op[i]     = '0;
      in_amt[i]    = '0;
      out_ready[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_output("reset_in_ready", 32'(in_ready[i]), 32'd1);
      check_output("reset_out_valid", 32'(out_valid[i]), 32'd0);
      check_output("reset_out_data", 32'(out_data[i]), 32'd0);
      check_output("reset_flags", {29'd0, out_carry[i], out_zero[i], out_neg[i]}, 32'd0);
    end

    $display("[TB] directed cases");
    apply_stimulus(0, 16'h8001, 3'b011, 1, 0, rd, rc, rz, rn);
    check_output("asr_data", 32'(rd), 32'hC000);
    check_output("asr_carry_neg", {30'd0, rc, rn}, 32'd3);

    apply_stimulus(0, 16'h00FF, 3'b001, 4, 0, rd, rc, rz, rn);
    check_output("lsl_data", 32'(rd), 32'h0FF0);
    check_output("lsl_carry", 32'(rc), 32'd0);

    apply_stimulus(1, 16'hFFFF, 3'b010, 20, 0, rd, rc, rz, rn);
    check_output("lsr_sat_data", 32'(rd), 32'h0000);
    check_output("lsr_sat_zero_carry", {30'd0, rz, rc}, 32'd3);

    apply_stimulus(0, 16'h0001, 3'b101, 17, 0, rd, rc, rz, rn);
    check_output("ror_data", 32'(rd), 32'h8000);
    check_output("ror_carry_neg", {30'd0, rc, rn}, 32'd3);

    apply_stimulus(0, 16'h1234, 3'b110, 5, 0, rd, rc, rz, rn);
    check_output("op110_data", 32'(rd), 32'h1234);
    check_output("op110_carry", 32'(rc), 32'd0);

    apply_stimulus(0, 16'hA5A5, 3'b100, 3, 5, rd, rc, rz, rn);
    check_output("backpressure_data", 32'(rd), 32'h2D2D);

    $display("[TB] flush and reset aborts");
    abort_test(1'b0, "flush");
    abort_test(1'b1, "reset");

    $display("[TB] randomized cases");
    for (int n = 0; n < 60; n++) begin
      u    = n % 2;
      d    = 16'($urandom);
      op   = 3'($urandom_range(0, 7));
      amt  = int'($urandom_range(0, 31));
      hold = int'($urandom_range(0, 2));
      apply_stimulus(u, d, op, amt, hold, rd, rc, rz, rn);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 The block SHALL take parameter WIDTH, default 16: data width in bits, minimum 2.
REQ-002 The block SHALL take parameter STEP, default 1: maximum bit positions shifted per cycle, range 1..WIDTH.
REQ-003 The block SHALL use local constant AW = $clog2(WIDTH)+1 as the shift-amount width.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: `clk  in  1  rising-edge clock`.
REQ-005 `reset  in  1  synchronous active-high reset`.
REQ-006 `flush  in  1  synchronous abort of the current operation`.
REQ-007 `in_valid  in  1  request valid`.
REQ-008 `in_ready  out  1  unit can accept a request`.
REQ-009 `in_data  in  WIDTH  operand`.
REQ-010 `in_op  in  3  operation: 000 pass, 001 LSL, 010 LSR, 011 ASR, 100 ROL, 101 ROR; 110/111 are treated as pass`.
REQ-011 `in_amt  in  AW  shift amount`.
REQ-012 `out_valid  out  1  result valid`.
REQ-013 `out_ready  in  1  consumer accepts the result`.
REQ-014 `out_data  out  WIDTH  result`.
REQ-015 `out_carry  out  1  last bit shifted or rotated out`.
REQ-016 `out_zero  out  1  out_data == 0`.
REQ-017 `out_neg  out  1  out_data[WIDTH-1]`.

Function
REQ-018 The state machine SHALL have the states IDLE, SHIFT and DONE; only one operation is in flight at a time.
REQ-019 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-020 A request SHALL be accepted on a clock edge where in_valid and in_ready are both 1; on acceptance, in_data, in_op and the effective amount are registered.
REQ-021 The effective amount SHALL be computed as follows:
- pass: 0.
- LSL/LSR/ASR: min(in_amt, WIDTH).
- ROL/ROR: in_amt mod WIDTH.
REQ-022 After acceptance, the next state SHALL be SHIFT if the effective amount is greater than 0, else DONE.
REQ-023 Each SHIFT cycle SHALL shift by min(STEP, remaining) and decrement remaining by the same value; the machine moves to DONE when remaining reaches 0.
REQ-024 For an effective amount k > 0, out_valid SHALL rise exactly ceil(k/STEP) cycles after the accept edge; for k = 0 it SHALL rise 1 cycle after the accept edge.
REQ-025 Fill rules:
- LSL fills the LSBs with 0.
- LSR fills the MSBs with 0.
- ASR fills the MSBs with copies of the original bit WIDTH-1.
- ROL and ROR wrap around.
REQ-026 out_carry SHALL be the last bit leaving the word (LSL/LSR/ASR) or the last bit wrapped (ROL/ROR), and SHALL be 0 when k = 0.
REQ-027 In DONE, out_data and all flags SHALL be held stable until out_ready = 1; on that edge the machine returns to IDLE.
REQ-028 A new request SHALL NOT be accepted on the same edge that a result is consumed; in_ready rises the cycle after consumption.
REQ-029 flush = 1 in any state SHALL return the machine to IDLE on the next edge, discard the in-flight operation and clear out_valid; a simultaneous in_valid is not accepted.
REQ-030 When reset and flush are asserted together, reset SHALL take precedence.
REQ-031 out_data and the flags SHALL be 0 whenever out_valid = 0.

Reset
REQ-032 On any edge where reset = 1, including mid-operation, the block SHALL enter IDLE with out_valid=0, out_data=0, out_carry=0, out_zero=0, out_neg=0 and the remaining count at 0.
REQ-033 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-034 The op codes and the IDLE/SHIFT/DONE state encoding SHALL reside in the shared package shift_pkg.
REQ-035 The combinational single-step datapath SHALL be the sub-module shift_step, with inputs data, op and amount (0..STEP) and outputs shifted data and carry; shift_unit instantiates it once.

Verification
REQ-036 WIDTH=16, STEP=1: ASR 16'h8001 amt 1 SHALL produce 16'hC000, carry=1, neg=1, with out_valid 1 cycle after accept.
REQ-037 WIDTH=16, STEP=1: LSL 16'h00FF amt 4 SHALL produce 16'h0FF0, carry=0, with out_valid 4 cycles after accept.
REQ-038 WIDTH=16, STEP=4: LSR 16'hFFFF amt 20 (saturates to 16) SHALL produce 16'h0000, zero=1, carry=1, with out_valid 4 cycles after accept.
REQ-039 WIDTH=16, STEP=1: ROR 16'h0001 amt 17 (effective 1) SHALL produce 16'h8000, carry=1, neg=1; op 110 with 16'h1234 SHALL produce 16'h1234, carry=0.
REQ-040 Backpressure: with out_ready=0 for 5 cycles in DONE, out_data and flags SHALL stay stable and in_ready SHALL stay 0; after consumption, in_ready SHALL be 1 the next cycle.
REQ-041 flush, and separately reset, asserted in the 2nd SHIFT cycle of LSL amt 8 SHALL produce IDLE on the next edge with out_valid=0 and in_ready=1; a following LSL 16'h0001 amt 1 SHALL produce 16'h0002.
